// File: rtl/ro_puf_word_if.sv
`timescale 1ns/1ps
// Challenge/response handshake between the PUF engine and its front end.
interface ro_puf_word_if #(
    parameter int SEL_W  = 4,
    parameter int N_BITS = 8
);
    logic                start;
    logic [2*SEL_W-1:0]  chall;
    logic                busy;
    logic                done;
    logic [N_BITS-1:0]   resp;
    logic                tie;
    logic                unstable;

    modport master (output start, chall, input busy, done, resp, tie, unstable);
    modport slave  (input start, chall, output busy, done, resp, tie, unstable);
endinterface

// File: rtl/ro_puf_word.sv
`timescale 1ns/1ps
// Ring-oscillator PUF engine: races one RO from each bank over a clock window,
// majority-votes N_VOTE races per bit and assembles an N_BITS response word.
module ro_puf_word #(
    parameter int N_RO   = 16,
    parameter int N_BITS = 8,
    parameter int N_VOTE = 3,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_RO-1:0] ro_a,
    input  logic [N_RO-1:0] ro_b,
    output logic            ro_en,
    ro_puf_word_if.slave    puf
);
    localparam int SEL_W  = $clog2(N_RO);
    localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int VIDX_W = (N_VOTE > 1) ? $clog2(N_VOTE) : 1;
    localparam int WINS_W = $clog2(N_VOTE + 1);
    localparam int TMR_W  = $clog2(WINDOW);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COUNT, S_SETTLE, S_COMPARE, S_DONE
    } state_t;

    state_t              r_state;
    logic [2*SEL_W-1:0]  r_chall;
    logic [BIT_W-1:0]    r_bit;
    logic [VIDX_W-1:0]   r_vote;
    logic [WINS_W-1:0]   r_wins;
    logic [TMR_W-1:0]    r_tmr;
    logic                r_clr;
    logic                r_cnt_en;
    logic                r_busy;
    logic                r_done;
    logic [N_BITS-1:0]   r_resp;
    logic                r_tie;
    logic                r_unstable;

    logic [1:0]          r_en_sync_a, r_en_sync_b;
    logic [CNT_W-1:0]    r_cnt_a, r_cnt_b;

    logic [SEL_W-1:0]    w_sel_a, w_sel_b;
    logic                w_ro_a, w_ro_b;
    logic                w_clr_n;
    logic                w_win;
    logic                w_eq;
    logic [WINS_W-1:0]   w_wins_next;

    // Power-of-two bank size makes the modulo a plain truncating add.
    assign w_sel_a = r_chall[SEL_W-1:0] + SEL_W'(r_bit);
    assign w_sel_b = r_chall[2*SEL_W-1:SEL_W] + SEL_W'(r_bit);
    assign w_ro_a  = ro_a[w_sel_a];
    assign w_ro_b  = ro_b[w_sel_b];
    assign w_clr_n = rst & ~r_clr;

    // NOTE: the RO-domain counters have no relation to clk, so they are cleared
    // asynchronously; r_clr is a registered FSM output and therefore glitch-free.
    always_ff @(posedge w_ro_a or negedge w_clr_n) begin
        if (!w_clr_n) begin
            r_en_sync_a <= '0;
            r_cnt_a     <= '0;
        end else begin
            r_en_sync_a <= {r_en_sync_a[0], r_cnt_en};
            if (r_en_sync_a[1] && (r_cnt_a != '1))
                r_cnt_a <= r_cnt_a + CNT_W'(1);
        end
    end

    always_ff @(posedge w_ro_b or negedge w_clr_n) begin
        if (!w_clr_n) begin
            r_en_sync_b <= '0;
            r_cnt_b     <= '0;
        end else begin
            r_en_sync_b <= {r_en_sync_b[0], r_cnt_en};
            if (r_en_sync_b[1] && (r_cnt_b != '1))
                r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
    end

    // Counters are frozen by SETTLE, so they are safe to read in COMPARE.
    assign w_win       = (r_cnt_a > r_cnt_b);
    assign w_eq        = (r_cnt_a == r_cnt_b);
    assign w_wins_next = r_wins + WINS_W'(w_win);

    // NOTE: all FSM state uses non-blocking assignments so every branch sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_chall    <= '0;
            r_bit      <= '0;
            r_vote     <= '0;
            r_wins     <= '0;
            r_tmr      <= '0;
            r_clr      <= 1'b0;
            r_cnt_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_resp     <= '0;
            r_tie      <= 1'b0;
            r_unstable <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if ((r_state == S_DONE) && !r_done) begin
                        // Final cycle of the run: publish the completed word.
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else if (puf.start) begin
                        r_chall    <= puf.chall;
                        r_bit      <= '0;
                        r_vote     <= '0;
                        r_wins     <= '0;
                        r_tmr      <= '0;
                        r_resp     <= '0;
                        r_tie      <= 1'b0;
                        r_unstable <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_clr      <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_tmr == TMR_W'(1)) begin
                        r_tmr    <= '0;
                        r_clr    <= 1'b0;
                        r_cnt_en <= 1'b1;
                        r_state  <= S_COUNT;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_COUNT: begin
                    if (r_tmr == TMR_W'(WINDOW - 1)) begin
                        r_tmr    <= '0;
                        r_cnt_en <= 1'b0;
                        r_state  <= S_SETTLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_tmr == TMR_W'(3)) begin
                        r_tmr   <= '0;
                        r_state <= S_COMPARE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_COMPARE: begin
                    if (w_eq)
                        r_tie <= 1'b1;
                    if (r_vote == VIDX_W'(N_VOTE - 1)) begin
                        r_resp[r_bit] <= (w_wins_next > WINS_W'(N_VOTE / 2));
                        if ((w_wins_next != '0) && (w_wins_next != WINS_W'(N_VOTE)))
                            r_unstable <= 1'b1;
                        r_wins <= '0;
                        r_vote <= '0;
                        if (r_bit == BIT_W'(N_BITS - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_clr   <= 1'b1;
                            r_state <= S_CLEAR;
                        end
                    end else begin
                        r_wins  <= w_wins_next;
                        r_vote  <= r_vote + VIDX_W'(1);
                        r_clr   <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ro_en        = r_busy;
    assign puf.busy     = r_busy;
    assign puf.done     = r_done;
    assign puf.resp     = r_resp;
    assign puf.tie      = r_tie;
    assign puf.unstable = r_unstable;

endmodule

// File: tb/tb_ro_puf_word.sv
`timescale 1ns/1ps
// Directed bench for ro_puf_word: table of RO frequency/challenge cases plus
// hand-written reset, vote-instability and mid-run reset sequences.
module tb_ro_puf_word;
    localparam int N_RO = 4, N_BITS = 4, N_VOTE = 3, CNT_W = 8, WINDOW = 32;
    localparam int LAT  = N_BITS * N_VOTE * (WINDOW + 7) + 1;

    logic            clk;
    logic            rst;
    logic [N_RO-1:0] ro_a, ro_b;
    logic            ro_en;
    int              tick;
    int              ha [N_RO] = '{4, 6, 8, 12};
    int              hb [N_RO] = '{7, 7, 7, 7};
    int              n_vec = 0;
    int              n_err = 0;

    ro_puf_word_if #(.SEL_W(2), .N_BITS(N_BITS)) puf ();

    ro_puf_word #(
        .N_RO(N_RO), .N_BITS(N_BITS), .N_VOTE(N_VOTE), .CNT_W(CNT_W), .WINDOW(WINDOW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ro_a  (ro_a),
        .ro_b  (ro_b),
        .ro_en (ro_en),
        .puf   (puf)
    );

    // Clock edges sit on a .25 ns offset so they never coincide with RO edges.
    initial begin
        clk = 1'b0;
        #0.25;
        forever #5 clk = ~clk;
    end

    // 0.5 ns tick; an RO of period P ns toggles every P ticks, all phase-aligned.
    initial begin
        tick = 0;
        forever begin
            #0.5;
            tick++;
        end
    end

    always_comb begin
        for (int i = 0; i < N_RO; i++) begin
            ro_a[i] = ((tick / ha[i]) % 2) != 0;
            ro_b[i] = ((tick / hb[i]) % 2) != 0;
        end
    end

    typedef struct {
        string      name;
        logic [31:0] pa;      // {p3,p2,p1,p0} bank-A periods in ns
        int         pb;       // bank-B period in ns (all four)
        logic [3:0] chall;    // {B,A}
        bit         mid_start;
        logic [3:0] exp_resp;
        logic       exp_tie;
        logic       exp_unst;
        int         exp_cnt;  // expected final counter value, -1 = unchecked
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_periods(input logic [31:0] pa, input int pb);
        for (int i = 0; i < N_RO; i++) begin
            ha[i] = int'(pa[8*i +: 8]);
            hb[i] = pb;
        end
    endtask

    task automatic accept(input logic [3:0] ch);
        @(negedge clk);
        puf.start = 1'b1;
        puf.chall = ch;
        @(posedge clk);
        #1;
        puf.start = 1'b0;
        puf.chall = ~ch;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        set_periods(v.pa, v.pb);
        accept(v.chall);
        check({v.name, " busy@accept"}, 32'(puf.busy), 32'd1);
        check({v.name, " ro_en@accept"}, 32'(ro_en), 32'd1);
        check({v.name, " done@accept"}, 32'(puf.done), 32'd0);
        n = 0;
        while (!puf.done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            puf.start = v.mid_start && (n == 100);
        end
        puf.start = 1'b0;
        check({v.name, " latency"}, 32'(n), 32'(LAT));
        check({v.name, " resp"}, 32'(puf.resp), 32'(v.exp_resp));
        check({v.name, " tie"}, 32'(puf.tie), 32'(v.exp_tie));
        check({v.name, " unstable"}, 32'(puf.unstable), 32'(v.exp_unst));
        check({v.name, " busy@done"}, 32'(puf.busy), 32'd0);
        if (v.exp_cnt >= 0) begin
            check({v.name, " cnt_a"}, 32'(dut.r_cnt_a), 32'(v.exp_cnt));
            check({v.name, " cnt_b"}, 32'(dut.r_cnt_b), 32'(v.exp_cnt));
        end
        repeat (3) @(posedge clk);
        #1;
        check({v.name, " done held"}, 32'(puf.done), 32'd1);
        check({v.name, " resp held"}, 32'(puf.resp), 32'(v.exp_resp));
    endtask

    initial begin
        int n;
        vecs[0] = '{"order",    {8'd12, 8'd8, 8'd6, 8'd4}, 7, 4'h0, 1'b0, 4'b0011, 1'b0, 1'b0, -1};
        vecs[1] = '{"wrap",     {8'd12, 8'd8, 8'd6, 8'd4}, 7, 4'h3, 1'b0, 4'b0110, 1'b0, 1'b0, -1};
        vecs[2] = '{"tie7",     {8'd7,  8'd7, 8'd7, 8'd7}, 7, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, -1};
        vecs[3] = '{"sat1",     {8'd1,  8'd1, 8'd1, 8'd1}, 1, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 255};
        vecs[4] = '{"midstart", {8'd12, 8'd8, 8'd6, 8'd4}, 7, 4'h0, 1'b1, 4'b0011, 1'b0, 1'b0, -1};

        // Reset and idle: ROs run but nothing is enabled or counted.
        rst = 1'b0;
        puf.start = 1'b0;
        puf.chall = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(puf.busy), 32'd0);
        check("rst done", 32'(puf.done), 32'd0);
        check("rst resp", 32'(puf.resp), 32'd0);
        check("rst flags", {30'd0, puf.tie, puf.unstable}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle ro_en", 32'(ro_en), 32'd0);
        check("idle busy", 32'(puf.busy), 32'd0);
        check("idle cnt_a", 32'(dut.r_cnt_a), 32'd0);
        check("idle cnt_b", 32'(dut.r_cnt_b), 32'd0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i]);

        // Vote instability on bit 0: races win, lose, win.
        set_periods({8'd12, 8'd8, 8'd6, 8'd4}, 7);
        accept(4'h0);
        n = 0;
        while (!puf.done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 40) ha[0] = 12;
            if (n == 79) ha[0] = 4;
        end
        check("vote latency", 32'(n), 32'(LAT));
        check("vote resp", 32'(puf.resp), 32'b0011);
        check("vote unstable", 32'(puf.unstable), 32'd1);
        check("vote tie", 32'(puf.tie), 32'd0);

        // Reset during COUNT of a later race, after bit 0 has been written.
        accept(4'h0);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pre-rst resp0", 32'(puf.resp), 32'b0001);
        #2;
        rst = 1'b0;
        #1;
        check("midrst busy", 32'(puf.busy), 32'd0);
        check("midrst ro_en", 32'(ro_en), 32'd0);
        check("midrst done", 32'(puf.done), 32'd0);
        check("midrst resp", 32'(puf.resp), 32'd0);
        check("midrst cnt_a", 32'(dut.r_cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
